// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a small FIFO: batches pops into drain bursts, hides the
// FIFO's one-cycle read latency behind a 2-entry skid buffer, and forwards words over valid/ready.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int TIMEOUT    = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  al_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  burst_done
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_next;
    logic                  rd_pend;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic                  pop;
    logic                  room;
    logic                  rd_next;
    logic                  burst_next;

    assign out_valid = (occ != 2'd0);
    assign out_data  = skid0;
    assign pop       = out_valid && out_ready;

    // A new read may only go out if, counting the word already in flight,
    // the buffer still has a free slot once this cycle's pop is accounted for.
    assign room = ({1'b0, occ} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        burst_next = 1'b0;
        rd_next    = (state == DRAIN) && enable && !fifo_empty && !fifo_rd && room;
        case (state)
            IDLE: begin
                if (enable && !al_empty) begin
                    state_next = DRAIN;
                    wait_next  = '0;
                end else if (fifo_empty) begin
                    wait_next = '0;
                end else if (enable) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = DRAIN;
                        wait_next  = '0;
                    end else begin
                        wait_next = wait_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !fifo_rd && !rd_pend) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (occ == 2'd0) begin
                    state_next = IDLE;
                    burst_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            fifo_rd    <= 1'b0;
            rd_pend    <= 1'b0;
            burst_done <= 1'b0;
            words_read <= '0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_next;
            fifo_rd    <= rd_next;
            rd_pend    <= fifo_rd;
            burst_done <= burst_next;
            if (pop) begin
                words_read <= words_read + 1'b1;
            end
        end
    end

    // Skid buffer: skid0 is always the head; a simultaneous push and pop keeps occ.
    always_ff @(posedge clk) begin
        if (RESET) begin
            occ   <= 2'd0;
            skid0 <= '0;
            skid1 <= '0;
        end else begin
            case ({rd_pend, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid0 <= fifo_data;
                    end else begin
                        skid1 <= fifo_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= fifo_data;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
